// File: rtl/uart_rx_stream_if.sv
// Byte stream carried out of uart_rx_stream: tdata/tvalid from the receiver, tready from the consumer.
interface uart_rx_stream_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;

   modport master (
      output tdata,
      output tvalid,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      output tready
   );
endinterface

// File: rtl/uart_rx_stream.sv
// RS-232 receiver (8N1, or 8E1 with UART_RX_STREAM_PARITY_EN defined) feeding a one-byte stream holding register.
// Flags framing errors, overruns and (option only) parity errors as single-cycle pulses.
module uart_rx_stream #(
   parameter int frequency = 50_000_000,
   parameter int bps       = 115_200
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             serial_in,
   uart_rx_stream_if.master m_axis,
   output logic             framing_error,
   output logic             overrun,
   output logic             parity_error
);

   localparam int PERIOD = (frequency + bps / 2) / bps;
   localparam int HALF   = PERIOD / 2;
   // Enough magnitude bits for PERIOD-2 plus a sign bit that marks expiry.
   localparam int TW     = $clog2(PERIOD + 1) + 1;

   localparam logic [TW-1:0] LOAD_PERIOD = TW'(PERIOD - 2);
   localparam logic [TW-1:0] LOAD_HALF   = TW'(HALF - 2);
   localparam logic [TW-1:0] TIMER_ONE   = TW'(1);

   if (PERIOD < 4) begin : g_bad_period
      $error("uart_rx_stream: frequency/bps must give at least 4 clocks per bit");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   logic [1:0]    r_rst_sync;
   logic          w_rst_n;
   logic [1:0]    r_sync;
   logic          w_rx;
   logic          w_expired;

   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic          r_rx_prev;
   logic [7:0]    r_shift;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_tdata;
   logic          r_tvalid;
   logic          r_framing;
   logic          r_overrun;
`ifdef UART_RX_STREAM_PARITY_EN
   logic          r_par_bad;
   logic          r_parity;
`endif

   // Reset asserts at once but releases on a clock edge, so no flop sees a runt release.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rst_sync <= 2'b00;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end
   assign w_rst_n = r_rst_sync[1];

   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], serial_in};
      end
   end
   assign w_rx      = r_sync[1];
   assign w_expired = r_timer[TW-1];

   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state   <= S_IDLE;
         r_timer   <= '0;
         r_rx_prev <= 1'b1;
         r_shift   <= '0;
         r_bit_idx <= '0;
         r_tdata   <= '0;
         r_tvalid  <= 1'b0;
         r_framing <= 1'b0;
         r_overrun <= 1'b0;
`ifdef UART_RX_STREAM_PARITY_EN
         r_par_bad <= 1'b0;
         r_parity  <= 1'b0;
`endif
      end else begin
         r_rx_prev <= w_rx;
         r_framing <= 1'b0;
         r_overrun <= 1'b0;
`ifdef UART_RX_STREAM_PARITY_EN
         r_parity  <= 1'b0;
`endif
         // The timer parks once expired; every state that uses it reloads it first.
         if (!w_expired) begin
            r_timer <= r_timer - TIMER_ONE;
         end
         if (r_tvalid && m_axis.tready) begin
            r_tvalid <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (r_rx_prev && !w_rx) begin
                  r_timer <= LOAD_HALF;
                  r_state <= S_START;
               end
            end

            S_START: begin
               if (w_expired) begin
                  if (w_rx) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_timer   <= LOAD_PERIOD;
                     r_bit_idx <= 3'd0;
                     r_state   <= S_DATA;
                  end
               end
            end

            S_DATA: begin
               if (w_expired) begin
                  r_shift   <= {w_rx, r_shift[7:1]};
                  r_timer   <= LOAD_PERIOD;
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_STREAM_PARITY_EN
                     r_state <= S_PARITY;
`else
                     r_state <= S_STOP;
`endif
                  end
               end
            end

`ifdef UART_RX_STREAM_PARITY_EN
            S_PARITY: begin
               if (w_expired) begin
                  r_par_bad <= w_rx ^ (^r_shift);
                  r_timer   <= LOAD_PERIOD;
                  r_state   <= S_STOP;
               end
            end
`endif

            S_STOP: begin
               if (w_expired) begin
                  if (!w_rx) begin
                     r_framing <= 1'b1;
                     r_state   <= S_WAIT_IDLE;
`ifdef UART_RX_STREAM_PARITY_EN
                  end else if (r_par_bad) begin
                     r_parity <= 1'b1;
                     r_state  <= S_IDLE;
`endif
                  end else begin
                     r_state <= S_IDLE;
                     // A byte consumed on this same edge frees the register for the new one.
                     if (!r_tvalid || m_axis.tready) begin
                        r_tdata  <= r_shift;
                        r_tvalid <= 1'b1;
                     end else begin
                        r_overrun <= 1'b1;
                     end
                  end
               end
            end

            S_WAIT_IDLE: begin
               if (w_rx) begin
                  r_state <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign m_axis.tdata  = r_tdata;
   assign m_axis.tvalid = r_tvalid;
   assign framing_error = r_framing;
   assign overrun       = r_overrun;
`ifdef UART_RX_STREAM_PARITY_EN
   assign parity_error  = r_parity;
`else
   assign parity_error  = 1'b0;
`endif

   a_errors_exclusive: assert property (@(posedge clock) disable iff (!w_rst_n)
      $onehot0({framing_error, overrun, parity_error}));

   a_hold_stable: assert property (@(posedge clock) disable iff (!w_rst_n)
      (r_tvalid && !m_axis.tready) |=> (r_tvalid && $stable(r_tdata)));

endmodule

// File: tb/tb_uart_rx_stream.sv
// Self-checking bench for uart_rx_stream: serial frames built bit by bit, results checked against expected byte lists.
// Works for both the 8N1 default and the UART_RX_STREAM_PARITY_EN build.
`timescale 1ns/1ps
module tb_uart_rx_stream;

   localparam int FREQ   = 1_000_000;
   localparam int BPS    = 100_000;
   localparam int PERIOD = (FREQ + BPS / 2) / BPS;
   localparam int HALF   = PERIOD / 2;
`ifdef UART_RX_STREAM_PARITY_EN
   localparam int NBITS  = 9;
`else
   localparam int NBITS  = 8;
`endif
   // Stop-bit centre on the line, plus two synchroniser clocks and one register clock.
   localparam int DELIVER_CLK = (1 + NBITS) * PERIOD + HALF + 3;

   logic clock;
   logic reset_n;
   logic serial_in;
   logic framing_error;
   logic overrun;
   logic parity_error;

   uart_rx_stream_if s_if ();

   uart_rx_stream #(
      .frequency (FREQ),
      .bps       (BPS)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .serial_in     (serial_in),
      .m_axis        (s_if),
      .framing_error (framing_error),
      .overrun       (overrun),
      .parity_error  (parity_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   int n_frame  = 0;
   int n_ovr    = 0;
   int n_par    = 0;
   int n_rise   = 0;
   logic [7:0] got_q[$];
   logic       prev_valid = 1'b0;
   logic       prev_ready = 1'b0;
   logic [7:0] prev_data  = 8'h00;
`ifdef UART_RX_STREAM_PARITY_EN
   logic       par_flip = 1'b0;
`endif

   // Observer: counts pulses, records transfers, and checks a held byte never changes.
   always @(negedge clock) begin
      if (framing_error) n_frame++;
      if (overrun) n_ovr++;
      if (parity_error) n_par++;
      if (s_if.tvalid && !prev_valid) n_rise++;
      if (prev_valid && !prev_ready && reset_n) begin
         n_checks++;
         if (!(s_if.tvalid === 1'b1 && s_if.tdata === prev_data)) begin
            n_fail++;
            $display("FAIL hold_stable: tvalid=%b tdata=%h, required tvalid=1 tdata=%h",
                     s_if.tvalid, s_if.tdata, prev_data);
         end
      end
      if (s_if.tvalid && s_if.tready) got_q.push_back(s_if.tdata);
      prev_valid = s_if.tvalid;
      prev_ready = s_if.tready;
      prev_data  = s_if.tdata;
   end

   task automatic wait_clk();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      serial_in = 1'b1;
      repeat (n) wait_clk();
   endtask

   task automatic clear_obs();
      n_frame = 0;
      n_ovr   = 0;
      n_par   = 0;
      n_rise  = 0;
      got_q.delete();
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      serial_in = 1'b0;
      repeat (PERIOD) wait_clk();
      for (int i = 0; i < 8; i++) begin
         serial_in = d[i];
         repeat (PERIOD) wait_clk();
      end
`ifdef UART_RX_STREAM_PARITY_EN
      serial_in = (^d) ^ par_flip;
      repeat (PERIOD) wait_clk();
`endif
      serial_in = stop_bit;
      repeat (PERIOD) wait_clk();
   endtask

   task automatic test_reset();
      reset_n     = 1'b0;
      serial_in   = 1'b1;
      s_if.tready = 1'b0;
      repeat (4) wait_clk();
      n_checks++;
      if (s_if.tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_tvalid: got %b, required 0", s_if.tvalid);
      end
      n_checks++;
      if (s_if.tdata !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_tdata: got %h, required 00", s_if.tdata);
      end
      n_checks++;
      if ({framing_error, overrun, parity_error} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_pulses: got %b, required 000", {framing_error, overrun, parity_error});
      end
      reset_n = 1'b1;
      idle(6);
      $display("test_reset: done");
   endtask

   task automatic test_basic();
      s_if.tready = 1'b1;
      clear_obs();
      fork
         send_frame(8'h55, 1'b1);
         begin
            repeat (DELIVER_CLK - 1) wait_clk();
            n_checks++;
            if (s_if.tvalid !== 1'b0) begin
               n_fail++;
               $display("FAIL latency_early: tvalid=%b one clock before delivery, required 0", s_if.tvalid);
            end
            wait_clk();
            n_checks++;
            if (s_if.tvalid !== 1'b1 || s_if.tdata !== 8'h55) begin
               n_fail++;
               $display("FAIL latency_edge: tvalid=%b tdata=%h, required 1 55", s_if.tvalid, s_if.tdata);
            end
         end
      join
      idle(3);
      send_frame(8'hA3, 1'b1);
      idle(6);
      n_checks++;
      if (got_q.size() != 2 || got_q[0] !== 8'h55 || got_q[1] !== 8'hA3) begin
         n_fail++;
         $display("FAIL basic_bytes: got %0d bytes %p, required 55 a3", got_q.size(), got_q);
      end
      n_checks++;
      if (n_rise != 2 || n_frame != 0 || n_ovr != 0 || n_par != 0) begin
         n_fail++;
         $display("FAIL basic_flags: rises=%0d frame=%0d ovr=%0d par=%0d, required 2 0 0 0",
                  n_rise, n_frame, n_ovr, n_par);
      end
      $display("test_basic: 0x55 and 0xA3 sent, %0d bytes received", got_q.size());
   endtask

   task automatic test_glitch();
      logic [7:0] d;
      s_if.tready = 1'b1;
      clear_obs();
      serial_in = 1'b0;
      repeat (3) wait_clk();
      idle(30);
      n_checks++;
      if (n_rise != 0 || n_frame != 0 || n_ovr != 0 || n_par != 0) begin
         n_fail++;
         $display("FAIL glitch_quiet: rises=%0d frame=%0d ovr=%0d par=%0d, required all 0",
                  n_rise, n_frame, n_ovr, n_par);
      end
      d = 8'($urandom);
      send_frame(d, 1'b1);
      idle(6);
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== d) begin
         n_fail++;
         $display("FAIL glitch_recover: got %p, required %h", got_q, d);
      end
      $display("test_glitch: 3-clock glitch, then byte %h", d);
   endtask

   task automatic test_framing();
      s_if.tready = 1'b1;
      clear_obs();
      send_frame(8'h3C, 1'b0);
      serial_in = 1'b0;
      repeat (30) wait_clk();
      idle(10);
      send_frame(8'h81, 1'b1);
      idle(6);
      n_checks++;
      if (n_frame != 1) begin
         n_fail++;
         $display("FAIL framing_count: got %0d pulse clocks, required 1", n_frame);
      end
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== 8'h81) begin
         n_fail++;
         $display("FAIL framing_bytes: got %p, required 81 only", got_q);
      end
      n_checks++;
      if (n_ovr != 0 || n_par != 0) begin
         n_fail++;
         $display("FAIL framing_other: ovr=%0d par=%0d, required 0 0", n_ovr, n_par);
      end
      $display("test_framing: 0x3C with low stop, break, then 0x81");
   endtask

   task automatic test_overrun();
      s_if.tready = 1'b0;
      clear_obs();
      send_frame(8'h11, 1'b1);
      idle(3);
      send_frame(8'h22, 1'b1);
      idle(6);
      n_checks++;
      if (s_if.tvalid !== 1'b1 || s_if.tdata !== 8'h11) begin
         n_fail++;
         $display("FAIL overrun_hold: tvalid=%b tdata=%h, required 1 11", s_if.tvalid, s_if.tdata);
      end
      n_checks++;
      if (n_ovr != 1) begin
         n_fail++;
         $display("FAIL overrun_count: got %0d pulse clocks, required 1", n_ovr);
      end
      s_if.tready = 1'b1;
      wait_clk();
      s_if.tready = 1'b0;
      idle(3);
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== 8'h11 || s_if.tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_drain: got %p tvalid=%b, required 11 and tvalid 0", got_q, s_if.tvalid);
      end
      $display("test_overrun: 0x11 held, 0x22 dropped");
   endtask

   task automatic test_back_to_back();
      s_if.tready = 1'b0;
      clear_obs();
      send_frame(8'h11, 1'b1);
      idle(3);
      fork
         send_frame(8'h22, 1'b1);
         begin
            repeat (DELIVER_CLK - 1) wait_clk();
            s_if.tready = 1'b1;
            wait_clk();
            s_if.tready = 1'b0;
            n_checks++;
            if (s_if.tvalid !== 1'b1 || s_if.tdata !== 8'h22) begin
               n_fail++;
               $display("FAIL same_cycle_load: tvalid=%b tdata=%h, required 1 22", s_if.tvalid, s_if.tdata);
            end
         end
      join
      idle(3);
      n_checks++;
      if (n_ovr != 0 || got_q.size() != 1 || got_q[0] !== 8'h11) begin
         n_fail++;
         $display("FAIL same_cycle_xfer: ovr=%0d got %p, required 0 and 11", n_ovr, got_q);
      end
      s_if.tready = 1'b1;
      wait_clk();
      s_if.tready = 1'b0;
      idle(2);
      n_checks++;
      if (got_q.size() != 2 || got_q[1] !== 8'h22) begin
         n_fail++;
         $display("FAIL same_cycle_drain: got %p, required 11 22", got_q);
      end
      $display("test_back_to_back: 0x11 consumed on the edge 0x22 loaded");
   endtask

   task automatic test_reset_midframe();
      s_if.tready = 1'b0;
      clear_obs();
      send_frame(8'h5A, 1'b1);
      idle(3);
      fork
         send_frame(8'hF0, 1'b1);
         begin
            repeat (5 * PERIOD + HALF) wait_clk();
            reset_n = 1'b0;
            #1;
            n_checks++;
            if (s_if.tvalid !== 1'b0 || s_if.tdata !== 8'h00) begin
               n_fail++;
               $display("FAIL midframe_reset: tvalid=%b tdata=%h, required 0 00", s_if.tvalid, s_if.tdata);
            end
            wait_clk();
            reset_n = 1'b1;
         end
      join
      idle(6);
      n_checks++;
      if (s_if.tvalid !== 1'b0 || n_frame != 0) begin
         n_fail++;
         $display("FAIL midframe_after: tvalid=%b frame=%0d, required 0 0", s_if.tvalid, n_frame);
      end
      s_if.tready = 1'b1;
      clear_obs();
      send_frame(8'h0F, 1'b1);
      idle(6);
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== 8'h0F) begin
         n_fail++;
         $display("FAIL midframe_next: got %p, required 0f", got_q);
      end
      $display("test_reset_midframe: 0xF0 aborted, 0x0F received");
   endtask

   task automatic test_random();
      logic [7:0] exp_q[$];
      logic [7:0] d;
      logic       bad;
      int         exp_frame;
      int         gap;
      exp_frame   = 0;
      s_if.tready = 1'b1;
      clear_obs();
      for (int k = 0; k < 14; k++) begin
         d   = 8'($urandom);
         bad = ($urandom_range(0, 3) == 0);
         send_frame(d, !bad);
         if (bad) begin
            exp_frame++;
            gap = $urandom_range(5, 20);
         end else begin
            exp_q.push_back(d);
            gap = $urandom_range(0, 20);
         end
         $display("test_random: frame %0d data %h stop %b gap %0d", k, d, !bad, gap);
         idle(gap);
      end
      idle(8);
      n_checks++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL random_count: got %0d bytes, required %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (i >= got_q.size()) begin
            n_fail++;
            $display("FAIL random_byte%0d: got nothing, required %h", i, exp_q[i]);
         end else if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL random_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]);
         end
      end
      n_checks++;
      if (n_frame != exp_frame || n_ovr != 0 || n_par != 0) begin
         n_fail++;
         $display("FAIL random_flags: frame=%0d ovr=%0d par=%0d, required %0d 0 0",
                  n_frame, n_ovr, n_par, exp_frame);
      end
   endtask

`ifdef UART_RX_STREAM_PARITY_EN
   task automatic test_parity();
      s_if.tready = 1'b1;
      clear_obs();
      par_flip = 1'b1;
      send_frame(8'h07, 1'b1);
      par_flip = 1'b0;
      idle(6);
      n_checks++;
      if (n_par != 1 || n_rise != 0 || got_q.size() != 0 || n_frame != 0) begin
         n_fail++;
         $display("FAIL parity_bad: par=%0d rises=%0d bytes=%0d frame=%0d, required 1 0 0 0",
                  n_par, n_rise, got_q.size(), n_frame);
      end
      send_frame(8'h07, 1'b1);
      idle(6);
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== 8'h07 || n_par != 1) begin
         n_fail++;
         $display("FAIL parity_good: got %p par=%0d, required 07 and 1", got_q, n_par);
      end
      $display("test_parity: 0x07 with parity 0 then 1");
   endtask
`endif

   initial begin
      reset_n     = 1'b0;
      serial_in   = 1'b1;
      s_if.tready = 1'b0;
      test_reset();
      test_basic();
      test_glitch();
      test_framing();
      test_overrun();
      test_back_to_back();
      test_reset_midframe();
      test_random();
`ifdef UART_RX_STREAM_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
